// File: rtl/div_pkg.sv
// Shared types and sizing for the sequential restoring divider.
// Holds the FSM state enum, default width N and the iteration counter width.
package div_pkg;

    localparam int N_DEF = 8;
    localparam int CNT_W_DEF = $clog2(2 * N_DEF);

    typedef enum logic [1:0] {
        IDLE,
        ITER,
        FIX
    } state_e;

    // Counter width for a 2N-cycle iteration loop.
    function automatic int cnt_w(input int n);
        return $clog2(2 * n);
    endfunction

endpackage

// File: rtl/seq_divider_if.sv
// Start/done handshake and operand/result bundle for seq_divider.
// master: start, dividend, divisor out; slave: busy, done, quot, rem, ovf, dz out.
interface seq_divider_if
    import div_pkg::*;
#(
    parameter int N = N_DEF
);
    logic             start;
    logic [2*N-1:0]   dividend;
    logic [N-1:0]     divisor;
    logic             busy;
    logic             done;
    logic [N-1:0]     quot;
    logic [N-1:0]     rem;
    logic             ovf;
    logic             dz;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quot, rem, ovf, dz
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quot, rem, ovf, dz
    );
endinterface

// File: rtl/div_step.sv
// One combinational restoring-division stage.
// Ports: prem_i partial remainder, bit_i next dividend bit, dvm_i divisor
// magnitude; prem_o next partial remainder, q_o quotient bit.
module div_step
    import div_pkg::*;
#(
    parameter int N = N_DEF
) (
    input  logic [N:0]   prem_i,
    input  logic         bit_i,
    input  logic [N-1:0] dvm_i,
    output logic [N:0]   prem_o,
    output logic         q_o
);
    logic [N+1:0] sh;
    logic [N+1:0] diff;

    // The shifted remainder is below 2*divisor, so N+2 bits keep the
    // sign of the trial subtraction exact.
    assign sh     = {prem_i, bit_i};
    assign diff   = sh - {2'b00, dvm_i};
    assign q_o    = ~diff[N+1];
    assign prem_o = q_o ? diff[N:0] : sh[N:0];
endmodule

// File: rtl/seq_divider.sv
// Sequential radix-2 restoring divider: 2N-bit dividend / N-bit divisor,
// fixed latency 2N+2. Ports: clk, rst (async, active high), bus (slave).
// Optional macro DIVIDER_SIGNED_EN selects two's-complement operation.
module seq_divider
    import div_pkg::*;
#(
    parameter int N = N_DEF
) (
    input  logic        clk,
    input  logic        rst,
    seq_divider_if.slave bus
);
    localparam int CW = cnt_w(N);
    localparam logic [CW-1:0] LAST = CW'(2 * N - 1);

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [N:0]      prem_q, prem_d;
    logic [2*N-1:0]  acc_q, acc_d;
    logic [N-1:0]    dvm_q, dvm_d;
    logic [N-1:0]    lo_q, lo_d;
    logic [N-1:0]    quot_q, quot_d;
    logic [N-1:0]    rem_q, rem_d;
    logic            ovf_q, ovf_d;
    logic            dz_q, dz_d;
    logic            done_q, done_d;
    logic [N:0]      step_rem;
    logic            step_q;
`ifdef DIVIDER_SIGNED_EN
    logic            sn_q, sn_d;
    logic            sd_q, sd_d;
    logic [2*N-1:0]  qf;
    logic [N-1:0]    rf;
`endif

    div_step #(.N(N)) u_step (
        .prem_i (prem_q),
        .bit_i  (acc_q[2*N-1]),
        .dvm_i  (dvm_q),
        .prem_o (step_rem),
        .q_o    (step_q)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        prem_d  = prem_q;
        acc_d   = acc_q;
        dvm_d   = dvm_q;
        lo_d    = lo_q;
        quot_d  = quot_q;
        rem_d   = rem_q;
        ovf_d   = ovf_q;
        dz_d    = dz_q;
        done_d  = 1'b0;
`ifdef DIVIDER_SIGNED_EN
        sn_d    = sn_q;
        sd_d    = sd_q;
        qf      = (sn_q ^ sd_q) ? -acc_q : acc_q;
        rf      = sn_q ? -prem_q[N-1:0] : prem_q[N-1:0];
`endif
        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = ITER;
                    cnt_d   = '0;
                    prem_d  = '0;
                    lo_d    = bus.dividend[N-1:0];
`ifdef DIVIDER_SIGNED_EN
                    sn_d    = bus.dividend[2*N-1];
                    sd_d    = bus.divisor[N-1];
                    acc_d   = bus.dividend[2*N-1] ? -bus.dividend
                                                  : bus.dividend;
                    dvm_d   = bus.divisor[N-1] ? -bus.divisor
                                               : bus.divisor;
`else
                    acc_d   = bus.dividend;
                    dvm_d   = bus.divisor;
`endif
                end
            end
            ITER: begin
                // acc shifts out dividend bits and fills with quotient bits
                prem_d = step_rem;
                acc_d  = {acc_q[2*N-2:0], step_q};
                cnt_d  = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                state_d = IDLE;
                done_d  = 1'b1;
                dz_d    = 1'b0;
`ifdef DIVIDER_SIGNED_EN
                quot_d  = qf[N-1:0];
                rem_d   = rf;
                // fits iff bits 2N-1..N-1 are a pure sign extension
                ovf_d   = !((&qf[2*N-1:N-1]) || !(|qf[2*N-1:N-1]));
`else
                quot_d  = acc_q[N-1:0];
                rem_d   = prem_q[N-1:0];
                ovf_d   = |acc_q[2*N-1:N];
`endif
                if (dvm_q == '0) begin
                    quot_d = '1;
                    rem_d  = lo_q;
                    ovf_d  = 1'b0;
                    dz_d   = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            prem_q  <= '0;
            acc_q   <= '0;
            dvm_q   <= '0;
            lo_q    <= '0;
            quot_q  <= '0;
            rem_q   <= '0;
            ovf_q   <= 1'b0;
            dz_q    <= 1'b0;
            done_q  <= 1'b0;
`ifdef DIVIDER_SIGNED_EN
            sn_q    <= 1'b0;
            sd_q    <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            prem_q  <= prem_d;
            acc_q   <= acc_d;
            dvm_q   <= dvm_d;
            lo_q    <= lo_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            ovf_q   <= ovf_d;
            dz_q    <= dz_d;
            done_q  <= done_d;
`ifdef DIVIDER_SIGNED_EN
            sn_q    <= sn_d;
            sd_q    <= sd_d;
`endif
        end
    end

    assign bus.busy = (state_q != IDLE);
    assign bus.done = done_q;
    assign bus.quot = quot_q;
    assign bus.rem  = rem_q;
    assign bus.ovf  = ovf_q;
    assign bus.dz   = dz_q;
endmodule
